// File: rtl/gw_video_pkg.sv
// Shared video types and constants for the segment compositor.
//   SEG_ID_W / SEG_COUNT : segment id width and number of LCD segments
//   RGB_W                : packed pixel width (8 bits per channel)
//   rgb_t                : r/g/b struct, r in the top byte
//   seg_state_e          : segment-RAM maintenance FSM states
//   blend_chan           : one-channel alpha blend, truncated to 8 bits
package gw_video_pkg;

   localparam int SEG_ID_W  = 10;
   localparam int SEG_COUNT = 1024;
   localparam int RGB_W     = 24;
   localparam int CNT_W     = SEG_ID_W + 1;   // COPY counts 0..SEG_COUNT

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      COPY  = 2'd2
   } seg_state_e;

   // (bg*(256-alpha) + seg*alpha) >> 8 on a 17-bit intermediate; the
   // result keeps only bits [15:8].
   function automatic logic [7:0] blend_chan(input logic [7:0] bg,
                                             input logic [7:0] seg,
                                             input logic [7:0] alpha);
      logic [16:0] acc;
      acc = 17'(bg) * (17'd256 - 17'(alpha)) + 17'(seg) * 17'(alpha);
      return acc[15:8];
   endfunction

endpackage

// File: rtl/segment_blend.sv
// Stage 2 of the video pipeline: per-channel alpha blend of the lit-segment
// colour over the background, plus the output register.
//   clk, reset : clock, synchronous active-high reset
//   lit_i      : blend this pixel (segment present, lit, RAMs ready)
//   de_i       : stage-1 pixel valid
//   bg_i       : stage-1 background pixel
//   rgb_o      : registered composited pixel, 0 when de_i was low
//   de_o       : registered de_i
module segment_blend
   import gw_video_pkg::*;
#(
   parameter logic [RGB_W-1:0] SEG_RGB   = 24'h101010,
   parameter logic [7:0]       SEG_ALPHA = 8'd224
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lit_i,
   input  logic             de_i,
   input  logic [RGB_W-1:0] bg_i,
   output logic [RGB_W-1:0] rgb_o,
   output logic             de_o
);

   rgb_t seg_c;
   rgb_t bg_c;
   rgb_t mix_c;
   rgb_t rgb_d;
   rgb_t rgb_q;
   logic de_q;

   assign seg_c = rgb_t'(SEG_RGB);
   assign bg_c  = rgb_t'(bg_i);

   assign mix_c.r = blend_chan(bg_c.r, seg_c.r, SEG_ALPHA);
   assign mix_c.g = blend_chan(bg_c.g, seg_c.g, SEG_ALPHA);
   assign mix_c.b = blend_chan(bg_c.b, seg_c.b, SEG_ALPHA);

   always_comb begin
      rgb_d = '0;
      if (de_i) begin
         rgb_d = lit_i ? mix_c : bg_c;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_q <= '0;
         de_q  <= 1'b0;
      end else begin
         rgb_q <= rgb_d;
         de_q  <= de_i;
      end
   end

   assign rgb_o = rgb_q;
   assign de_o  = de_q;

endmodule

// File: rtl/segment_compositor.sv
// Composites lit LCD segments over the background video.
// A CPU-written shadow segment RAM is copied into a display RAM once per
// frame at vblank start, so the picture never shows a half-updated frame.
// Video path: 2-cycle latency, no stalls. de is a plain per-pixel valid with
// no ready/backpressure; every cycle's input produces an output 2 cycles on.
//   clk, reset     : clock, synchronous active-high reset
//   seg_wr*        : shadow RAM write (dropped while clearing)
//   vblank         : vertical blank; rising edge starts a copy
//   has_segment, segment_id, bg_rgb, de : pixel stream from the mask stage
//   rgb_out, de_out: composited pixel and its valid
//   ready          : post-reset RAM clear finished
//   copy_overrun   : sticky, vblank fell while a copy was running
//   fsm_state      : current maintenance FSM state (debug)
module segment_compositor
   import gw_video_pkg::*;
#(
   parameter logic [RGB_W-1:0] SEG_RGB   = 24'h101010,
   parameter logic [7:0]       SEG_ALPHA = 8'd224
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                seg_wr,
   input  logic [SEG_ID_W-1:0] seg_wr_addr,
   input  logic                seg_wr_data,
   input  logic                vblank,
   input  logic                has_segment,
   input  logic [SEG_ID_W-1:0] segment_id,
   input  logic [RGB_W-1:0]    bg_rgb,
   input  logic                de,
   output logic [RGB_W-1:0]    rgb_out,
   output logic                de_out,
   output logic                ready,
   output logic                copy_overrun,
   output seg_state_e          fsm_state
);

   localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(SEG_COUNT - 1);
   localparam logic [CNT_W-1:0] COPY_END  = CNT_W'(SEG_COUNT);

   seg_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ready_q;
   logic             overrun_q;
   logic             vblank_q;

   logic vb_rise;
   logic vb_fall;
   assign vb_rise = vblank & ~vblank_q;
   assign vb_fall = ~vblank & vblank_q;

   // Maintenance FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR;
         cnt_q     <= '0;
         ready_q   <= 1'b0;
         overrun_q <= 1'b0;
         vblank_q  <= 1'b0;
      end else begin
         vblank_q <= vblank;
         case (state_q)
            CLEAR: begin
               if (cnt_q == LAST_ADDR) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            IDLE: begin
               if (vb_rise) begin
                  state_q <= COPY;
                  cnt_q   <= '0;
               end
            end
            COPY: begin
               // A new vblank rise is ignored; a fall only flags the overrun.
               if (vb_fall) begin
                  overrun_q <= 1'b1;
               end
               if (cnt_q == COPY_END) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= CLEAR;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // RAM write ports
   logic                shadow_we;
   logic [SEG_ID_W-1:0] shadow_waddr;
   logic                shadow_wdata;
   logic                disp_we;
   logic [SEG_ID_W-1:0] disp_waddr;
   logic                disp_wdata;
   logic                shadow_rd_q;
   logic [SEG_ID_W-1:0] copy_prev_addr;

   // The copy write trails the shadow read by one cycle.
   assign copy_prev_addr = cnt_q[SEG_ID_W-1:0] - 1'b1;

   always_comb begin
      shadow_we    = 1'b0;
      shadow_waddr = seg_wr_addr;
      shadow_wdata = seg_wr_data;
      disp_we      = 1'b0;
      disp_waddr   = copy_prev_addr;
      disp_wdata   = shadow_rd_q;
      if (!reset) begin
         case (state_q)
            CLEAR: begin
               shadow_we    = 1'b1;
               shadow_waddr = cnt_q[SEG_ID_W-1:0];
               shadow_wdata = 1'b0;
               disp_we      = 1'b1;
               disp_waddr   = cnt_q[SEG_ID_W-1:0];
               disp_wdata   = 1'b0;
            end
            IDLE: begin
               shadow_we = seg_wr;
            end
            COPY: begin
               shadow_we = seg_wr;
               disp_we   = (cnt_q != '0);
            end
            default: begin
               shadow_we = 1'b0;
            end
         endcase
      end
   end

   // Shadow RAM: port A CPU/clear write, port B copy read. The read sees the
   // pre-write value when both hit the same address in one cycle.
   logic shadow_mem [SEG_COUNT];

   always_ff @(posedge clk) begin
      if (shadow_we) begin
         shadow_mem[shadow_waddr] <= shadow_wdata;
      end
      shadow_rd_q <= shadow_mem[cnt_q[SEG_ID_W-1:0]];
   end

   // Display RAM: port A copy/clear write, port B video read.
   logic disp_mem [SEG_COUNT];
   logic disp_rd_q;

   always_ff @(posedge clk) begin
      if (disp_we) begin
         disp_mem[disp_waddr] <= disp_wdata;
      end
      disp_rd_q <= disp_mem[segment_id];
   end

   // Video stage 1: align the pixel with the RAM read.
   logic             has_q;
   logic [RGB_W-1:0] bg_q;
   logic             de_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         has_q <= 1'b0;
         bg_q  <= '0;
         de_q  <= 1'b0;
      end else begin
         has_q <= has_segment;
         bg_q  <= bg_rgb;
         de_q  <= de;
      end
   end

   // Video stage 2
   logic lit;
   assign lit = has_q & disp_rd_q & ready_q;

   segment_blend #(
      .SEG_RGB  (SEG_RGB),
      .SEG_ALPHA(SEG_ALPHA)
   ) u_blend (
      .clk  (clk),
      .reset(reset),
      .lit_i(lit),
      .de_i (de_q),
      .bg_i (bg_q),
      .rgb_o(rgb_out),
      .de_o (de_out)
   );

   assign ready        = ready_q;
   assign copy_overrun = overrun_q;
   assign fsm_state    = state_q;

endmodule

// File: tb/tb_segment_compositor.sv
// Bench for segment_compositor: directed phases with randomized pixels and
// shadow writes, checked against a frame-level model of the segment RAMs.
module tb_segment_compositor;
   import gw_video_pkg::*;

   localparam int          ALPHA   = 224;
   localparam logic [23:0] SEG_COL = 24'h101010;

   // Clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        seg_wr = 1'b0;
   logic [9:0]  seg_wr_addr = '0;
   logic        seg_wr_data = 1'b0;
   logic        vblank = 1'b0;
   logic        has_segment = 1'b0;
   logic [9:0]  segment_id = '0;
   logic [23:0] bg_rgb = '0;
   logic        de = 1'b0;
   logic [23:0] rgb_out;
   logic        de_out;
   logic        ready;
   logic        copy_overrun;
   seg_state_e  fsm_state;

   segment_compositor dut (
      .clk(clk), .reset(reset), .seg_wr(seg_wr), .seg_wr_addr(seg_wr_addr),
      .seg_wr_data(seg_wr_data), .vblank(vblank), .has_segment(has_segment),
      .segment_id(segment_id), .bg_rgb(bg_rgb), .de(de), .rgb_out(rgb_out),
      .de_out(de_out), .ready(ready), .copy_overrun(copy_overrun),
      .fsm_state(fsm_state)
   );

   // Reference model: whole-frame view of the segment RAMs
   bit sh_m   [1024];
   bit disp_m [1024];
   bit snap_m [1024];
   int clear_left = 1024;
   bit ready_m = 0;
   bit ovr_m = 0;
   bit copying_m = 0;
   int copy_cyc = 0;
   bit vb_prev_m = 0;

   // Scoreboard
   logic [24:0] exp_q[$];   // {de, rgb}
   bit          chk_q[$];
   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] mix(input logic [7:0] bg, input logic [7:0] sg);
      int v;
      v = (int'(bg) * (256 - ALPHA) + int'(sg) * ALPHA) / 256;
      return 8'(v);
   endfunction

   function automatic logic [24:0] exp_pix();
      logic [23:0] px;
      if (!de) return 25'd0;
      px = bg_rgb;
      if (has_segment && disp_m[segment_id] && ready_m) begin
         px = {mix(bg_rgb[23:16], SEG_COL[23:16]), mix(bg_rgb[15:8], SEG_COL[15:8]),
               mix(bg_rgb[7:0], SEG_COL[7:0])};
      end
      return {1'b1, px};
   endfunction

   function automatic seg_state_e exp_state();
      if (clear_left > 0) return CLEAR;
      if (copying_m) return COPY;
      return IDLE;
   endfunction

   // One clock: queue expectation, advance the model, compare.
   task automatic tick();
      logic [24:0] e;
      bit c;
      exp_q.push_back(exp_pix());
      chk_q.push_back((!copying_m && clear_left == 0) || !has_segment || !de);
      @(posedge clk);
      #1;
      if (reset) begin
         clear_left = 1024; ready_m = 0; ovr_m = 0; copying_m = 0; vb_prev_m = 0;
         exp_q.delete();
         chk_q.delete();
         exp_q.push_back(25'd0);
         chk_q.push_back(1'b1);
         check("rst_rgb", 32'(rgb_out), 32'd0);
         check("rst_de", 32'(de_out), 32'd0);
      end else begin
         if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) begin
               ready_m = 1;
               foreach (sh_m[i]) begin sh_m[i] = 0; disp_m[i] = 0; end
            end
         end else begin
            if (copying_m) begin
               if (copy_cyc < 1024) snap_m[copy_cyc] = sh_m[copy_cyc];
               if (vb_prev_m && !vblank) ovr_m = 1;
               copy_cyc++;
               if (copy_cyc == 1025) begin
                  disp_m = snap_m;
                  copying_m = 0;
               end
            end else if (vblank && !vb_prev_m) begin
               copying_m = 1;
               copy_cyc = 0;
            end
            if (seg_wr) sh_m[seg_wr_addr] = seg_wr_data;
         end
         vb_prev_m = vblank;
         if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            c = chk_q.pop_front();
            if (c) begin
               check("rgb_out", 32'(rgb_out), 32'(e[23:0]));
               check("de_out", 32'(de_out), 32'(e[24]));
            end
         end
      end
      check("ready", 32'(ready), 32'(ready_m));
      check("copy_overrun", 32'(copy_overrun), 32'(ovr_m));
      check("fsm_state", 32'(fsm_state), 32'(exp_state()));
   endtask

   // Driver tasks
   task automatic rand_pixel();
      has_segment = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
         0: segment_id = 10'd5;
         1: segment_id = 10'd512;
         2: segment_id = 10'($urandom_range(600, 1023));
         default: segment_id = 10'($urandom_range(0, 1023));
      endcase
      bg_rgb = 24'($urandom);
      de = ($urandom_range(0, 3) != 0);
   endtask

   task automatic rand_write();
      seg_wr = ($urandom_range(0, 3) == 0);
      seg_wr_addr = 10'($urandom_range(600, 1023));
      seg_wr_data = 1'($urandom_range(0, 1));
   endtask

   task automatic idle_pixel();
      has_segment = 0; de = 0; bg_rgb = '0; segment_id = '0;
   endtask

   task automatic rand_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         rand_pixel();
         rand_write();
         tick();
      end
      seg_wr = 0;
   endtask

   // Apply one pixel, then one idle cycle; rgb_out then shows that pixel.
   task automatic show_pixel(input logic [9:0] id, input logic [23:0] bg);
      seg_wr = 0;
      has_segment = 1; de = 1; segment_id = id; bg_rgb = bg;
      tick();
      idle_pixel();
      tick();
   endtask

   task automatic wait_copy_done(output int n);
      n = 0;
      while (fsm_state == COPY && n < 2000) begin
         rand_pixel();
         rand_write();
         tick();
         n++;
      end
      seg_wr = 0;
   endtask

   int n;
   int m;

   initial begin
      // Reset and the post-reset clear; plain background passes through.
      repeat (3) tick();
      reset = 0;
      for (int i = 0; i < 1100; i++) begin
         has_segment = 0;
         segment_id = 10'($urandom_range(0, 1023));
         bg_rgb = 24'($urandom);
         de = ($urandom_range(0, 3) != 0);
         rand_write();
         tick();
         if (i == 1022) check("ready_before_1024", 32'(ready), 32'd0);
         if (i == 1023) check("ready_at_1024", 32'(ready), 32'd1);
      end
      seg_wr = 0;

      // Write seg 5 without vblank: not visible yet.
      seg_wr = 1; seg_wr_addr = 10'd5; seg_wr_data = 1;
      idle_pixel();
      tick();
      show_pixel(10'd5, 24'hFFFFFF);
      check("seg5_before_copy", 32'(rgb_out), 32'hFFFFFF);

      // Copy; vblank held through the whole copy, so no overrun.
      vblank = 1;
      rand_pixel();
      tick();
      wait_copy_done(n);
      check("copy_len", 32'(n), 32'd1025);
      vblank = 0;
      rand_ticks(5);
      show_pixel(10'd5, 24'hFFFFFF);
      check("seg5_after_copy", 32'(rgb_out), 32'h2D2D2D);
      show_pixel(10'd5, 24'h000000);
      check("seg5_black_bg", 32'(rgb_out), 32'h0E0E0E);

      // Write to 512 on the exact cycle the copy reads 512.
      vblank = 1;
      rand_pixel();
      tick();
      rand_ticks(512);
      seg_wr = 1; seg_wr_addr = 10'd512; seg_wr_data = 1;
      tick();
      seg_wr = 0;
      wait_copy_done(n);
      check("copy_len_race", 32'(n), 32'd512);
      vblank = 0;
      rand_ticks(3);
      show_pixel(10'd512, 24'hFFFFFF);
      check("seg512_race_old", 32'(rgb_out), 32'hFFFFFF);
      vblank = 1;
      tick();
      wait_copy_done(n);
      vblank = 0;
      rand_ticks(3);
      show_pixel(10'd512, 24'hFFFFFF);
      check("seg512_next_frame", 32'(rgb_out), 32'h2D2D2D);
      check("no_overrun_yet", 32'(copy_overrun), 32'd0);

      // vblank falls 500 cycles into the copy.
      vblank = 1;
      tick();
      rand_ticks(500);
      vblank = 0;
      wait_copy_done(m);
      check("overrun_copy_len", 32'(500 + m), 32'd1025);
      check("overrun_set", 32'(copy_overrun), 32'd1);
      rand_ticks(50);
      vblank = 1;
      tick();
      wait_copy_done(m);
      vblank = 0;
      rand_ticks(5);
      check("overrun_sticky", 32'(copy_overrun), 32'd1);

      // Reset at counter=300 of a copy, then everything reads unlit.
      vblank = 1;
      tick();
      rand_ticks(300);
      reset = 1; vblank = 0;
      tick();
      check("reset_ready_low", 32'(ready), 32'd0);
      check("reset_overrun_low", 32'(copy_overrun), 32'd0);
      reset = 0;
      rand_ticks(1024);
      check("ready_after_clear", 32'(ready), 32'd1);
      for (int i = 0; i <= 1024; i++) begin
         if (i < 1024) begin
            has_segment = 1; de = 1; segment_id = 10'(i); bg_rgb = 24'hFFFFFF;
         end else begin
            idle_pixel();
         end
         tick();
         if (i >= 1) check("cleared_id", 32'(rgb_out), 32'hFFFFFF);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/segment_compositor.md
Name: segment_compositor

Overview:
- Downstream of the mask stage. Takes the per-pixel segment_id/has_segment stream and looks up whether that LCD segment is currently lit.
- Blends the lit-segment colour over the background pixel and emits the final RGB.
- Holds a shadow segment-state RAM written by the CPU-side LCD driver at any time. A display RAM is copied from the shadow once per frame at vblank start, so the picture never tears.

Parameters:
- SEG_RGB, 24'h101010, RGB colour of a lit segment.
- SEG_ALPHA, 8'd224, blend weight of the segment colour. 0 means background only; 255 means nearly opaque.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- seg_wr  in  1  write strobe for the shadow segment state
- seg_wr_addr  in  10  segment id to write
- seg_wr_data  in  1  1 = lit, 0 = unlit
- vblank  in  1  vertical blank, same timing as the mask stage input
- has_segment  in  1  from the mask stage
- segment_id  in  10  from the mask stage, aligned with has_segment
- bg_rgb  in  24  background pixel, aligned with has_segment
- de  in  1  pixel valid, aligned with has_segment
- rgb_out  out  24  composited pixel
- de_out  out  1  de delayed to match rgb_out
- ready  out  1  high once post-reset RAM clear has finished
- copy_overrun  out  1  sticky flag: vblank fell while a copy was in progress

Behaviour:
- Reset values: rgb_out=0, de_out=0, ready=0, copy_overrun=0. FSM enters CLEAR, counter=0.
- Storage:
  - shadow RAM: 1024x1. Port A is the CPU write; port B is the copy read, 1-cycle latency.
  - display RAM: 1024x1. Port A is the copy/clear write; port B is the video read, 1-cycle latency.
- FSM states:
  - CLEAR: writes 0 to addr counter in both RAMs each cycle. After addr 1023 is written, go to IDLE and set ready=1. Takes 1024 cycles.
    - seg_wr during CLEAR is dropped.
    - ready stays 1 until the next reset.
  - IDLE: on a vblank rising edge (vblank=1, previous vblank=0), go to COPY with counter=0.
  - COPY: issue shadow read of addr counter each cycle. One cycle later, write the returned bit to display[counter-1].
    - Returns to IDLE after display[1023] is written, 1025 cycles after entry.
    - A vblank rising edge while in COPY is ignored.
- seg_wr in IDLE or COPY is written to the shadow RAM on that cycle.
  - If seg_wr hits the address being copied on the same cycle, the copy reads the old value (read-before-write). The new value lands next frame.
- copy_overrun: set when vblank falls while the FSM is in COPY. Cleared only by reset. The copy still runs to completion.
- Reset mid-COPY or mid-CLEAR: return to CLEAR and restart from addr 0.
- Video pipeline (2-cycle latency, runs every cycle in every state):
  - Stage 1:
    - display RAM read at segment_id.
    - Register has_segment, bg_rgb and de.
  - Stage 2:
    - lit = stage-1 has_segment AND RAM bit AND ready.
    - Per channel c: out_c = lit ? (bg_c*(256-SEG_ALPHA) + seg_c*SEG_ALPHA) >> 8 : bg_c.
    - The 17-bit intermediate is truncated to 8 bits.
    - rgb_out <= de ? result : 0; de_out <= stage-1 de.
  - When ready=0, rgb_out passes the background through (with the same de gating).
- The output of a given pixel depends only on the inputs 2 cycles earlier. No stalls; no backpressure.

Decomposition:
- Shared package gw_video_pkg:
  - SEG_ID_W=10, SEG_COUNT=1024, RGB_W=24.
  - Typedef rgb_t (struct of r/g/b 8-bit).
  - The state enum {CLEAR, IDLE, COPY}.
- One sub-module, segment_blend: the combinational per-channel alpha blend, instantiated 3 times, plus the stage-2 register.
- RAMs are inferred dual-port, one per array.

Test Plan:
- Reset, then hold 1100 cycles → ready rises exactly 1024 cycles after reset deasserts. rgb_out equals the 2-cycle-delayed bg_rgb throughout.
- Write seg 5=1, no vblank, drive segment_id=5, has_segment=1, bg=FFFFFF, de=1 → rgb_out=FFFFFF (not yet copied).
- Same write, pulse vblank, wait 1025 cycles, repeat the pixel → rgb_out = each channel (255*32+16*224)>>8 = 45 = 2D2D2D, appearing 2 cycles after input.
- seg_wr addr 512 data 1 on the exact cycle the copy reads 512 → display[512] stays 0 this frame. After the next vblank it is 1.
- Drop vblank 500 cycles into COPY → copy_overrun=1. FSM still returns to IDLE at cycle 1025. The flag persists until reset.
- Assert reset during COPY at counter=300 → ready=0 next cycle. The display RAM reads 0 for all ids after the 1024-cycle CLEAR.
